// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch/decode front end:
// opcode constants, instruction-length encoding, fetch states, decode flags.
package cpu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_AND_IMM = 8'h29;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_ADC_ABS = 8'h6D;
    localparam logic [7:0] OP_AND_ABS = 8'h2D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_BEQ_REL = 8'hF0;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    // Instruction length in bytes (opcode plus operand bytes).
    typedef enum logic [1:0] {
        ILEN_1 = 2'd1,
        ILEN_2 = 2'd2,
        ILEN_3 = 2'd3
    } ilen_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_OP = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_FETCH_HI = 3'd3,
        ST_DONE     = 3'd4
    } fetch_state_t;

    // One-hot instruction class plus the illegal marker.
    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic arith_imm;
        logic arith_mem;
        logic illegal;
    } dec_flags_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode decode table: instruction class flags and length.
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output dec_flags_t flags_o,
    output ilen_t      len_o
);

    // Table lookup; anything not listed is illegal and treated as one byte long.
    always_comb begin
        flags_o = '0;
        len_o   = ILEN_1;
        case (opcode_i)
            OP_LDA_IMM: begin flags_o.arith_imm = 1'b1; len_o = ILEN_2; end
            OP_ADC_IMM: begin flags_o.arith_imm = 1'b1; len_o = ILEN_2; end
            OP_AND_IMM: begin flags_o.arith_imm = 1'b1; len_o = ILEN_2; end
            OP_LDA_ABS: begin flags_o.load      = 1'b1; len_o = ILEN_3; end
            OP_STA_ABS: begin flags_o.store     = 1'b1; len_o = ILEN_3; end
            OP_ADC_ABS: begin flags_o.arith_mem = 1'b1; len_o = ILEN_3; end
            OP_AND_ABS: begin flags_o.arith_mem = 1'b1; len_o = ILEN_3; end
            OP_JMP_ABS: begin flags_o.branch    = 1'b1; len_o = ILEN_3; end
            OP_BEQ_REL: begin flags_o.branch    = 1'b1; len_o = ILEN_2; end
            OP_NOP:     begin                           len_o = ILEN_1; end
            default:    begin flags_o.illegal   = 1'b1; len_o = ILEN_1; end
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: reads opcode and operand bytes from a
// byte-wide memory at the program counter and presents the decoded class.
//
// Memory handshake: mem_req rises when a fetch state is entered and stays high,
// with mem_addr held at pc, until mem_ack is sampled high on a rising clka; one
// byte transfers on each clock edge where mem_req && mem_ack. mem_ack seen while
// mem_req is low is ignored.
module instr_fetch_decode
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
)
(
    input  logic              clka,
    input  logic              restart_n,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        opcode,
    output logic [15:0]       operand,
    output logic              load,
    output logic              store,
    output logic              branch,
    output logic              arith_imm,
    output logic              arith_mem,
    output logic              illegal,
    output logic              valid,
    output logic              busy,
    output fetch_state_t      state_dbg
);

    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        opcode_q;
    logic [15:0]       operand_q;
    dec_flags_t        flags_q;
    logic              valid_q;
    logic              busy_q;
    logic              mem_req_q;

    logic [7:0]        dec_opcode;
    dec_flags_t        dec_flags;
    ilen_t             dec_len;
    logic [ADDR_W-1:0] pc_next;

    // While the opcode byte is arriving, decode it straight from memory so the
    // length is known on the same edge that captures it.
    assign dec_opcode = (state_q == ST_FETCH_OP) ? mem_rdata : opcode_q;
    assign pc_next    = pc_q + PC_INC;

    opcode_decode u_decode (
        .opcode_i (dec_opcode),
        .flags_o  (dec_flags),
        .len_o    (dec_len)
    );

    // Fetch sequencer: walks opcode/operand bytes and latches the decode on completion.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            opcode_q  <= OP_NOP;
            operand_q <= '0;
            flags_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pc_load) begin
                        pc_q <= pc_load_val;
                    end
                    if (fetch_start) begin
                        state_q   <= ST_FETCH_OP;
                        busy_q    <= 1'b1;
                        mem_req_q <= 1'b1;
                        flags_q   <= '0;
                        operand_q <= '0;
                    end
                end
                ST_FETCH_OP: begin
                    if (mem_ack) begin
                        opcode_q <= mem_rdata;
                        pc_q     <= pc_next;
                        if (dec_len == ILEN_1) begin
                            state_q   <= ST_DONE;
                            mem_req_q <= 1'b0;
                            valid_q   <= 1'b1;
                            flags_q   <= dec_flags;
                        end else begin
                            state_q <= ST_FETCH_LO;
                        end
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ack) begin
                        operand_q[7:0] <= mem_rdata;
                        pc_q           <= pc_next;
                        if (dec_len == ILEN_3) begin
                            state_q <= ST_FETCH_HI;
                        end else begin
                            state_q   <= ST_DONE;
                            mem_req_q <= 1'b0;
                            valid_q   <= 1'b1;
                            flags_q   <= dec_flags;
                        end
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ack) begin
                        operand_q[15:8] <= mem_rdata;
                        pc_q            <= pc_next;
                        state_q         <= ST_DONE;
                        mem_req_q       <= 1'b0;
                        valid_q         <= 1'b1;
                        flags_q         <= dec_flags;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign opcode    = opcode_q;
    assign operand   = operand_q;
    assign load      = flags_q.load;
    assign store     = flags_q.store;
    assign branch    = flags_q.branch;
    assign arith_imm = flags_q.arith_imm;
    assign arith_mem = flags_q.arith_mem;
    assign illegal   = flags_q.illegal;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
